// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction cache with line-burst refill and an uncached path for kseg1.
// Hits answer combinationally in IDLE; misses sequence one memory transaction to completion.
module icache_fetch_ctrl #(
   parameter int INDEX_BITS = 6,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic [31:0] pc_in,
   input  logic        inv_all,
   output logic        cache_ready,
   output logic [31:0] instr_out,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_single,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int OFF_BITS = $clog2(LINE_WORDS);
   localparam int TAG_BITS = 30 - OFF_BITS - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_REFILL,
      S_UNC_WAIT,
      S_UNC_DONE
   } state_e;

   state_e                state_q;
   logic [LINES-1:0]      valid_q;
   logic [OFF_BITS-1:0]   cnt_q;
   logic                  inv_pend_q;
   logic                  mem_req_q;
   logic [31:0]           addr_q;
   logic                  single_q;
   logic [31:0]           hold_q;

   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES][LINE_WORDS];

   logic [TAG_BITS-1:0]   pc_tag;
   logic [INDEX_BITS-1:0] pc_idx;
   logic [OFF_BITS-1:0]   pc_word;
   logic [TAG_BITS-1:0]   line_tag;
   logic [INDEX_BITS-1:0] line_idx;
   logic                  cacheable;
   logic                  hit;
   logic                  unc_match;
   logic                  refill_beat;
   logic                  last_beat;
   logic                  inv_now;
   logic                  unused_pc_lsb;

   assign pc_tag        = pc_in[31 -: TAG_BITS];
   assign pc_idx        = pc_in[OFF_BITS+2 +: INDEX_BITS];
   assign pc_word       = pc_in[2 +: OFF_BITS];
   assign line_tag      = addr_q[31 -: TAG_BITS];
   assign line_idx      = addr_q[OFF_BITS+2 +: INDEX_BITS];
   assign unused_pc_lsb = ^pc_in[1:0];

   assign cacheable   = (pc_in[31:29] != 3'b101);
   assign hit         = fetch_req && cacheable && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign unc_match   = fetch_req && (pc_in[31:2] == addr_q[31:2]);
   assign refill_beat = (state_q == S_REFILL) && mem_rvalid;
   assign last_beat   = refill_beat && (&cnt_q);
   assign inv_now     = inv_pend_q || inv_all;

   assign mem_req    = mem_req_q;
   assign mem_addr   = addr_q;
   assign mem_single = single_q;

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      cache_ready = 1'b0;
      instr_out   = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               cache_ready = 1'b1;
               instr_out   = data_q[pc_idx][pc_word];
            end
         end
         S_UNC_DONE: begin
            if (unc_match) begin
               cache_ready = 1'b1;
               instr_out   = hold_q;
            end
         end
         default: ;
      endcase
   end

   // NOTE: tag and data arrays carry no reset; the valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (refill_beat) begin
         data_q[line_idx][cnt_q] <= mem_rdata;
         if (last_beat) tag_q[line_idx] <= line_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         valid_q    <= '0;
         cnt_q      <= '0;
         inv_pend_q <= 1'b0;
         mem_req_q  <= 1'b0;
         addr_q     <= 32'h0;
         single_q   <= 1'b0;
         hold_q     <= 32'h0;
      end else begin
         // Invalidates arriving mid-transaction are deferred to the return to IDLE.
         if (state_q != S_IDLE && inv_all) inv_pend_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (inv_all) valid_q <= '0;
               if (fetch_req && !hit) begin
                  addr_q    <= cacheable ? (pc_in & ~LINE_MASK) : (pc_in & ~32'd3);
                  single_q  <= !cacheable;
                  mem_req_q <= 1'b1;
                  state_q   <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  mem_req_q <= 1'b0;
                  state_q   <= single_q ? S_UNC_WAIT : S_REFILL;
               end
            end
            S_REFILL: begin
               if (mem_rvalid) cnt_q <= cnt_q + 1'b1;
               if (last_beat) begin
                  valid_q[line_idx] <= 1'b1;
                  state_q           <= S_IDLE;
                  if (inv_now) begin
                     valid_q    <= '0;
                     inv_pend_q <= 1'b0;
                  end
               end
            end
            S_UNC_WAIT: begin
               if (mem_rvalid) begin
                  hold_q  <= mem_rdata;
                  state_q <= S_UNC_DONE;
               end
            end
            S_UNC_DONE: begin
               state_q <= S_IDLE;
               if (inv_now) begin
                  valid_q    <= '0;
                  inv_pend_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl: inputs change 1 ns after the rising edge,
// outputs are compared a few ns later, well before the next edge.
module tb_icache_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_req = 1'b0;
   logic [31:0] pc_in = 32'h0;
   logic        inv_all = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        cache_ready;
   logic [31:0] instr_out;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_single;

   int checks = 0;
   int failures = 0;

   icache_fetch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_req  (fetch_req),
      .pc_in      (pc_in),
      .inv_all    (inv_all),
      .cache_ready(cache_ready),
      .instr_out  (instr_out),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_single (mem_single),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in a REQ cycle with mem_ready=1; returns in the first IDLE cycle after the burst.
   task automatic drain_burst(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int inv_beat, input int redir_beat,
                              input logic [31:0] redir_pc);
      logic [31:0] w [4];
      w = '{w0, w1, w2, w3};
      tick();
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = w[k];
         inv_all    = (k == inv_beat);
         if (k == redir_beat) pc_in = redir_pc;
         tick();
      end
      mem_rvalid = 1'b0;
      inv_all    = 1'b0;
   endtask

   task automatic test_reset();
      fetch_req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_single !== 1'b0) begin failures++; $display("FAIL reset_mem_single got=%0b exp=0", mem_single); end
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", cache_ready); end
      checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
      tick();
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_no_fetch_req got=%0b exp=0", mem_req); end
   endtask

   task automatic test_cold_miss();
      fetch_req = 1'b1; pc_in = 32'h0040_0008; mem_ready = 1'b1;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL cold_miss_ready got=%0b exp=0", cache_ready); end
      tick(); #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL cold_req got=%0b exp=1", mem_req); end
      checks++; if (mem_addr !== 32'h0040_0000) begin failures++; $display("FAIL cold_addr got=%h exp=00400000", mem_addr); end
      checks++; if (mem_single !== 1'b0) begin failures++; $display("FAIL cold_single got=%0b exp=0", mem_single); end
      drain_burst(32'h11, 32'h22, 32'h33, 32'h44, -1, -1, 32'h0);
      #1;
      checks++; if (cache_ready !== 1'b1) begin failures++; $display("FAIL cold_fill_ready got=%0b exp=1", cache_ready); end
      checks++; if (instr_out !== 32'h33) begin failures++; $display("FAIL cold_fill_instr got=%h exp=33", instr_out); end
      for (int k = 0; k < 4; k++) begin
         pc_in = 32'h0040_0000 + 32'(4 * k);
         #1;
         checks++; if (cache_ready !== 1'b1 || instr_out !== 32'(32'h11 * (k + 1)))
            begin failures++; $display("FAIL cold_hit_w%0d ready=%0b instr=%h exp=%h", k, cache_ready, instr_out, 32'h11 * (k + 1)); end
         tick(); #1;
         checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_hit_noreq_w%0d got=%0b exp=0", k, mem_req); end
      end
      fetch_req = 1'b0;
   endtask

   task automatic test_uncached();
      fetch_req = 1'b1; pc_in = 32'hBFC0_0000; mem_ready = 1'b1;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL unc_idle_ready got=%0b exp=0", cache_ready); end
      tick(); #1;
      checks++; if (mem_req !== 1'b1 || mem_single !== 1'b1 || mem_addr !== 32'hBFC0_0000)
         begin failures++; $display("FAIL unc_req req=%0b single=%0b addr=%h exp=1/1/bfc00000", mem_req, mem_single, mem_addr); end
      tick(); #1;
      checks++; if (mem_req !== 1'b0 || cache_ready !== 1'b0)
         begin failures++; $display("FAIL unc_wait req=%0b ready=%0b exp=0/0", mem_req, cache_ready); end
      mem_rvalid = 1'b1; mem_rdata = 32'h3C08_BFC0;
      tick();
      mem_rvalid = 1'b0;
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'h3C08_BFC0)
         begin failures++; $display("FAIL unc_done ready=%0b instr=%h exp=1/3c08bfc0", cache_ready, instr_out); end
      tick(); #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL unc_not_installed got=%0b exp=0", cache_ready); end
      tick(); #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000)
         begin failures++; $display("FAIL unc_refetch_req req=%0b addr=%h exp=1/bfc00000", mem_req, mem_addr); end
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      pc_in = 32'hBFC0_0004;
      #1;
      checks++; if (cache_ready !== 1'b0 || instr_out !== 32'h0)
         begin failures++; $display("FAIL unc_redirect_discard ready=%0b instr=%h exp=0/0", cache_ready, instr_out); end
      fetch_req = 1'b0;
      tick();
   endtask

   task automatic test_req_hold();
      fetch_req = 1'b1; pc_in = 32'h0040_0030; mem_ready = 1'b0;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0030)
         begin failures++; $display("FAIL req_hold req=%0b addr=%h exp=1/00400030", mem_req, mem_addr); end
      mem_ready = 1'b1;
      drain_burst(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, -1, 32'h0);
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'hA0)
         begin failures++; $display("FAIL stray_rvalid_ignored ready=%0b instr=%h exp=1/a0", cache_ready, instr_out); end
      fetch_req = 1'b0;
   endtask

   task automatic test_conflict();
      fetch_req = 1'b1; pc_in = 32'h0040_1000; mem_ready = 1'b1;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL conflict_miss got=%0b exp=0", cache_ready); end
      tick(); #1;
      checks++; if (mem_addr !== 32'h0040_1000) begin failures++; $display("FAIL conflict_addr got=%h exp=00401000", mem_addr); end
      drain_burst(32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, -1, 32'h0);
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'hB0)
         begin failures++; $display("FAIL conflict_fill ready=%0b instr=%h exp=1/b0", cache_ready, instr_out); end
      pc_in = 32'h0040_0004;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL conflict_evicted got=%0b exp=0", cache_ready); end
      tick();
      drain_burst(32'h11, 32'h22, 32'h33, 32'h44, -1, -1, 32'h0);
      fetch_req = 1'b0;
   endtask

   task automatic test_redirect();
      fetch_req = 1'b0; inv_all = 1'b1;
      tick();
      inv_all = 1'b0;
      fetch_req = 1'b1; pc_in = 32'h0040_0000; mem_ready = 1'b1;
      tick();
      drain_burst(32'h51, 32'h52, 32'h53, 32'h54, -1, 2, 32'h0050_0000);
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL redirect_new_pc_miss got=%0b exp=0", cache_ready); end
      pc_in = 32'h0040_0004;
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'h52)
         begin failures++; $display("FAIL redirect_line_installed ready=%0b instr=%h exp=1/52", cache_ready, instr_out); end
      pc_in = 32'h0050_0000;
      tick(); #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0050_0000 || mem_single !== 1'b0)
         begin failures++; $display("FAIL redirect_req req=%0b addr=%h single=%0b exp=1/00500000/0", mem_req, mem_addr, mem_single); end
      drain_burst(32'h61, 32'h62, 32'h63, 32'h64, -1, -1, 32'h0);
      pc_in = 32'h0050_0008;
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'h63)
         begin failures++; $display("FAIL redirect_second_fill ready=%0b instr=%h exp=1/63", cache_ready, instr_out); end
      fetch_req = 1'b0;
   endtask

   task automatic test_inv_all();
      fetch_req = 1'b1; pc_in = 32'h0040_0010; mem_ready = 1'b1;
      tick();
      drain_burst(32'h71, 32'h72, 32'h73, 32'h74, 1, -1, 32'h0);
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL inv_refill_line_cleared got=%0b exp=0", cache_ready); end
      pc_in = 32'h0050_0000;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL inv_refill_other_cleared got=%0b exp=0", cache_ready); end
      pc_in = 32'h0040_0010;
      tick();
      drain_burst(32'h71, 32'h72, 32'h73, 32'h74, -1, -1, 32'h0);
      pc_in = 32'h0040_0014; inv_all = 1'b1;
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'h72)
         begin failures++; $display("FAIL inv_idle_same_cycle ready=%0b instr=%h exp=1/72", cache_ready, instr_out); end
      tick();
      inv_all = 1'b0;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL inv_idle_next_miss got=%0b exp=0", cache_ready); end
      tick(); #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0010)
         begin failures++; $display("FAIL inv_idle_refetch req=%0b addr=%h exp=1/00400010", mem_req, mem_addr); end
      drain_burst(32'h71, 32'h72, 32'h73, 32'h74, -1, -1, 32'h0);
      fetch_req = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      fetch_req = 1'b1; pc_in = 32'h0040_0020; mem_ready = 1'b1;
      tick();
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h81;
      tick();
      mem_rdata = 32'h82;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || cache_ready !== 1'b0 || mem_addr !== 32'h0)
         begin failures++; $display("FAIL async_reset req=%0b ready=%0b addr=%h exp=0/0/0", mem_req, cache_ready, mem_addr); end
      mem_rvalid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checks++; if (cache_ready !== 1'b0) begin failures++; $display("FAIL post_reset_miss got=%0b exp=0", cache_ready); end
      tick(); #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0020 || mem_single !== 1'b0)
         begin failures++; $display("FAIL post_reset_req req=%0b addr=%h single=%0b exp=1/00400020/0", mem_req, mem_addr, mem_single); end
      drain_burst(32'h91, 32'h92, 32'h93, 32'h94, -1, -1, 32'h0);
      #1;
      checks++; if (cache_ready !== 1'b1 || instr_out !== 32'h91)
         begin failures++; $display("FAIL post_reset_fill ready=%0b instr=%h exp=1/91", cache_ready, instr_out); end
      fetch_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_cold_miss();
      test_uncached();
      test_req_hold();
      test_conflict();
      test_redirect();
      test_inv_all();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
